ddr4_dq_rx_train: RTL and testbench
===================================

Name: ddr4_dq_rx_train

Overview:
Receive-side companion to the DDR4 output IOD lanes. It sits between one input IOD lane and the read datapath, on the fabric clock. It trains the IOD input delay line by sweeping taps against a known read pattern, with bit-slip if needed, and centres the tap in the data eye. After training it passes deserialized read data through to the controller.

Parameters:
MAX_TAPS, 128, number of delay-line taps swept (tap index 0..MAX_TAPS-1)
SETTLE_CYCLES, 8, FAB_CLK cycles waited after every LOAD/MOVE/SLIP before sampling
SAMPLE_CYCLES, 16, consecutive FAB_CLK cycles compared per tap
PATTERN, 4'b0101, expected RX_DATA_0 word every cycle during training
MIN_EYE, 4, minimum passing-window width in taps
MAX_SLIPS, 4, bit-slip attempts before failure

Ports:
FAB_CLK  in  1  fabric clock, all logic on rising edge
ARST  in  1  reset, asynchronous, active-high
TRAIN_START  in  1  single-cycle pulse; starts training from any non-busy state
RX_DATA_0  in  4  deserialized lane data from IOD
DELAY_LINE_OUT_OF_RANGE_0  in  1  IOD delay line at end of range
DELAY_LINE_LOAD_0  out  1  pulse; resets delay line to tap 0
DELAY_LINE_MOVE_0  out  1  pulse; move one tap
DELAY_LINE_DIRECTION_0  out  1  1 = increment, 0 = decrement; valid with MOVE
RX_BIT_SLIP_0  out  1  pulse; IOD rotates word alignment by one bit
RD_EN  in  1  read-data capture enable
RD_DATA  out  4  registered read data
RD_VALID  out  1  RD_DATA valid
TRAIN_BUSY  out  1  training in progress
TRAIN_DONE  out  1  sticky; eye found and centred
TRAIN_FAIL  out  1  sticky; no eye after MAX_SLIPS
EYE_FIRST  out  7  first passing tap
EYE_LAST  out  7  last passing tap
CENTER_TAP  out  7  final tap, floor((EYE_FIRST+EYE_LAST)/2)

Behaviour:
- Reset: all outputs 0; state IDLE; tap, slip, sample and settle counters 0.
- All pulse outputs are exactly one cycle wide. At most one of LOAD/MOVE/SLIP is active per cycle.
- States: IDLE, LOAD, SETTLE, SAMPLE, STEP, SLIP, CENTER, DONE, FAIL.
- IDLE/DONE/FAIL + TRAIN_START:
  - clear DONE, FAIL, EYE_*, CENTER_TAP, slip count; raise TRAIN_BUSY.
  - go LOAD: pulse LOAD, tap = 0, window flags cleared, then go SETTLE.
- SETTLE: wait SETTLE_CYCLES, then SAMPLE.
- SAMPLE: compare RX_DATA_0 to PATTERN for SAMPLE_CYCLES cycles. The tap passes only if all compares match. Then go STEP.
- STEP, window tracking:
  - Pass with no window open: EYE_FIRST = tap, open window.
  - Pass with window open: EYE_LAST = tap.
  - First fail after the window opened closes it.
  - Window closed with width (EYE_LAST-EYE_FIRST+1) >= MIN_EYE: go CENTER.
  - Window closed with width < MIN_EYE: discard it and keep sweeping.
  - Otherwise, if tap < MAX_TAPS-1 and DELAY_LINE_OUT_OF_RANGE_0 = 0: pulse MOVE with DIRECTION = 1, tap++, go SETTLE.
  - End of sweep (tap = MAX_TAPS-1 or OUT_OF_RANGE = 1): if a window is open with width >= MIN_EYE, go CENTER; else go SLIP.
- SLIP:
  - slip count < MAX_SLIPS: pulse RX_BIT_SLIP_0, slip count++, go LOAD.
  - slip count = MAX_SLIPS: go FAIL.
- CENTER:
  - CENTER_TAP = floor((EYE_FIRST+EYE_LAST)/2).
  - Issue MOVE pulses with DIRECTION = 0, one every SETTLE_CYCLES+1 cycles, decrementing tap until tap == CENTER_TAP.
  - Then go DONE.
- DONE: TRAIN_DONE = 1, BUSY = 0.
- FAIL: TRAIN_FAIL = 1, BUSY = 0, EYE_* = 0.
- TRAIN_START while BUSY is ignored.
- RD path:
  - RD_DATA <= RX_DATA_0 and RD_VALID <= RD_EN & ~TRAIN_BUSY, registered with 1-cycle latency.
  - RD_VALID is 0 throughout training.
- ARST mid-training: immediate return to IDLE, outputs 0. No LOAD is issued until the next TRAIN_START.

Test Plan:
1. Model eye at taps 40..59, no slip needed; pulse TRAIN_START. Expect EYE_FIRST=40, EYE_LAST=59, CENTER_TAP=49, 11 decrement MOVEs, TRAIN_DONE=1, RX_BIT_SLIP_0 never pulses.
2. Pattern valid only after 2 slips, eye 10..30. Expect exactly 2 SLIP pulses, each followed by a LOAD, then CENTER_TAP=20, DONE=1.
3. Pattern never matches. Expect 4 SLIP pulses, 5 full sweeps of 128 taps, TRAIN_FAIL=1, DONE=0, BUSY=0.
4. Narrow eye 5..6 plus wide eye 70..127 (open at sweep end). Expect narrow eye rejected, EYE_FIRST=70, EYE_LAST=127, CENTER_TAP=98, DONE=1.
5. OUT_OF_RANGE asserted at tap 64 with eye 60..64. Expect sweep stops at 64, CENTER_TAP=62, DONE=1.
6. Reset and read path:
   - Assert ARST mid-SAMPLE: all outputs 0 within the same cycle; a later TRAIN_START retrains normally.
   - After DONE with RD_EN=1, RX_DATA_0=4'hA: RD_DATA=4'hA and RD_VALID=1 one cycle later.

Source files
------------

// File: rtl/ddr4_dq_rx_train_if.sv
// Signal bundle between the DQ receive trainer, its input IOD lane and the read datapath.
// The trainer uses the slave modport; the lane/controller side uses master.
interface ddr4_dq_rx_train_if;
    logic       TRAIN_START;
    logic [3:0] RX_DATA_0;
    logic       DELAY_LINE_OUT_OF_RANGE_0;
    logic       DELAY_LINE_LOAD_0;
    logic       DELAY_LINE_MOVE_0;
    logic       DELAY_LINE_DIRECTION_0;
    logic       RX_BIT_SLIP_0;
    logic       RD_EN;
    logic [3:0] RD_DATA;
    logic       RD_VALID;
    logic       TRAIN_BUSY;
    logic       TRAIN_DONE;
    logic       TRAIN_FAIL;
    logic [6:0] EYE_FIRST;
    logic [6:0] EYE_LAST;
    logic [6:0] CENTER_TAP;

    modport slave (
        input  TRAIN_START,
        input  RX_DATA_0,
        input  DELAY_LINE_OUT_OF_RANGE_0,
        input  RD_EN,
        output DELAY_LINE_LOAD_0,
        output DELAY_LINE_MOVE_0,
        output DELAY_LINE_DIRECTION_0,
        output RX_BIT_SLIP_0,
        output RD_DATA,
        output RD_VALID,
        output TRAIN_BUSY,
        output TRAIN_DONE,
        output TRAIN_FAIL,
        output EYE_FIRST,
        output EYE_LAST,
        output CENTER_TAP
    );

    modport master (
        output TRAIN_START,
        output RX_DATA_0,
        output DELAY_LINE_OUT_OF_RANGE_0,
        output RD_EN,
        input  DELAY_LINE_LOAD_0,
        input  DELAY_LINE_MOVE_0,
        input  DELAY_LINE_DIRECTION_0,
        input  RX_BIT_SLIP_0,
        input  RD_DATA,
        input  RD_VALID,
        input  TRAIN_BUSY,
        input  TRAIN_DONE,
        input  TRAIN_FAIL,
        input  EYE_FIRST,
        input  EYE_LAST,
        input  CENTER_TAP
    );
endinterface

// File: rtl/ddr4_dq_rx_train.sv
// DDR4 DQ receive trainer: sweeps the IOD input delay line against a fixed read pattern,
// bit-slips when no eye is found, centres the tap in the eye, then forwards read data.
module ddr4_dq_rx_train #(
    parameter int unsigned MAX_TAPS      = 128,
    parameter int unsigned SETTLE_CYCLES = 8,
    parameter int unsigned SAMPLE_CYCLES = 16,
    parameter logic [3:0]  PATTERN       = 4'b0101,
    parameter int unsigned MIN_EYE       = 4,
    parameter int unsigned MAX_SLIPS     = 4
) (
    input  logic              FAB_CLK,
    input  logic              ARST,
    ddr4_dq_rx_train_if.slave bus
);

    localparam int unsigned CntMax = (SETTLE_CYCLES > SAMPLE_CYCLES) ? SETTLE_CYCLES
                                                                     : SAMPLE_CYCLES;
    localparam int unsigned CntW   = $clog2(CntMax + 1);
    localparam int unsigned SlipW  = $clog2(MAX_SLIPS + 1);

    localparam logic [CntW-1:0]  CntOne       = CntW'(1);
    localparam logic [CntW-1:0]  SettleLast   = CntW'(SETTLE_CYCLES - 1);
    localparam logic [CntW-1:0]  SettleReload = CntW'(SETTLE_CYCLES);
    localparam logic [CntW-1:0]  SampleLast   = CntW'(SAMPLE_CYCLES - 1);
    localparam logic [6:0]       LastTap      = 7'(MAX_TAPS - 1);
    localparam logic [7:0]       MinEye       = 8'(MIN_EYE);
    localparam logic [SlipW-1:0] SlipMax      = SlipW'(MAX_SLIPS);
    localparam logic [SlipW-1:0] SlipOne      = SlipW'(1);

    localparam logic [3:0] StIdle   = 4'd0;
    localparam logic [3:0] StLoad   = 4'd1;
    localparam logic [3:0] StSettle = 4'd2;
    localparam logic [3:0] StSample = 4'd3;
    localparam logic [3:0] StStep   = 4'd4;
    localparam logic [3:0] StSlip   = 4'd5;
    localparam logic [3:0] StCenter = 4'd6;
    localparam logic [3:0] StDone   = 4'd7;
    localparam logic [3:0] StFail   = 4'd8;

    logic [3:0]       state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [6:0]       tap_q, tap_d;
    logic [SlipW-1:0] slip_cnt_q, slip_cnt_d;
    logic             pass_q, pass_d;
    logic             win_q, win_d;
    logic [6:0]       first_q, first_d;
    logic [6:0]       last_q, last_d;
    logic [6:0]       center_q, center_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             fail_q, fail_d;
    logic             load_q, load_d;
    logic             move_q, move_d;
    logic             dir_q, dir_d;
    logic             slip_q, slip_d;
    logic [3:0]       rd_data_q;
    logic             rd_valid_q;

    // Window bounds as updated by the current tap result, before deciding where to go.
    logic [6:0]       s_first, s_last;
    logic             s_open;
    logic [7:0]       width;
    logic [7:0]       sum;
    logic             to_center;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        tap_d      = tap_q;
        slip_cnt_d = slip_cnt_q;
        pass_d     = pass_q;
        win_d      = win_q;
        first_d    = first_q;
        last_d     = last_q;
        center_d   = center_q;
        busy_d     = busy_q;
        done_d     = done_q;
        fail_d     = fail_q;
        load_d     = 1'b0;
        move_d     = 1'b0;
        slip_d     = 1'b0;
        dir_d      = dir_q;
        s_first    = first_q;
        s_last     = last_q;
        s_open     = win_q;
        width      = 8'd0;
        sum        = 8'd0;
        to_center  = 1'b0;

        unique case (state_q)
            StIdle, StDone, StFail: begin
                if (bus.TRAIN_START) begin
                    done_d     = 1'b0;
                    fail_d     = 1'b0;
                    first_d    = 7'd0;
                    last_d     = 7'd0;
                    center_d   = 7'd0;
                    slip_cnt_d = '0;
                    busy_d     = 1'b1;
                    state_d    = StLoad;
                end
            end

            StLoad: begin
                load_d  = 1'b1;
                tap_d   = 7'd0;
                win_d   = 1'b0;
                first_d = 7'd0;
                last_d  = 7'd0;
                cnt_d   = '0;
                state_d = StSettle;
            end

            StSettle: begin
                if (cnt_q == SettleLast) begin
                    cnt_d   = '0;
                    pass_d  = 1'b1;
                    state_d = StSample;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end

            StSample: begin
                pass_d = pass_q & (bus.RX_DATA_0 == PATTERN);
                if (cnt_q == SampleLast) begin
                    cnt_d   = '0;
                    state_d = StStep;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end

            StStep: begin
                if (pass_q) begin
                    if (!win_q) begin
                        s_first = tap_q;
                        s_last  = tap_q;
                        s_open  = 1'b1;
                    end else begin
                        s_last = tap_q;
                    end
                end
                width = {1'b0, s_last} - {1'b0, s_first} + 8'd1;
                sum   = {1'b0, s_first} + {1'b0, s_last};
                // A failing tap after an open window closes it; narrow windows are dropped.
                if (!pass_q && win_q) begin
                    if (width >= MinEye) begin
                        to_center = 1'b1;
                    end else begin
                        s_open = 1'b0;
                    end
                end
                first_d = s_first;
                last_d  = s_last;
                win_d   = s_open;

                if (!to_center && (tap_q < LastTap) && !bus.DELAY_LINE_OUT_OF_RANGE_0) begin
                    move_d  = 1'b1;
                    dir_d   = 1'b1;
                    tap_d   = tap_q + 7'd1;
                    cnt_d   = '0;
                    state_d = StSettle;
                end else if (to_center || (s_open && (width >= MinEye))) begin
                    center_d = 7'(sum >> 1);
                    cnt_d    = '0;
                    state_d  = StCenter;
                end else begin
                    state_d = StSlip;
                end
            end

            StSlip: begin
                if (slip_cnt_q < SlipMax) begin
                    slip_d     = 1'b1;
                    slip_cnt_d = slip_cnt_q + SlipOne;
                    state_d    = StLoad;
                end else begin
                    fail_d  = 1'b1;
                    busy_d  = 1'b0;
                    first_d = 7'd0;
                    last_d  = 7'd0;
                    state_d = StFail;
                end
            end

            StCenter: begin
                // Walk back one tap per settle period until the centre is reached.
                if (tap_q == center_q) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = StDone;
                end else if (cnt_q == '0) begin
                    move_d = 1'b1;
                    dir_d  = 1'b0;
                    tap_d  = tap_q - 7'd1;
                    cnt_d  = SettleReload;
                end else begin
                    cnt_d = cnt_q - CntOne;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge FAB_CLK or posedge ARST) begin
        if (ARST) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            tap_q      <= 7'd0;
            slip_cnt_q <= '0;
            pass_q     <= 1'b0;
            win_q      <= 1'b0;
            first_q    <= 7'd0;
            last_q     <= 7'd0;
            center_q   <= 7'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            fail_q     <= 1'b0;
            load_q     <= 1'b0;
            move_q     <= 1'b0;
            dir_q      <= 1'b0;
            slip_q     <= 1'b0;
            rd_data_q  <= 4'd0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tap_q      <= tap_d;
            slip_cnt_q <= slip_cnt_d;
            pass_q     <= pass_d;
            win_q      <= win_d;
            first_q    <= first_d;
            last_q     <= last_d;
            center_q   <= center_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            fail_q     <= fail_d;
            load_q     <= load_d;
            move_q     <= move_d;
            dir_q      <= dir_d;
            slip_q     <= slip_d;
            rd_data_q  <= bus.RX_DATA_0;
            // Gate with the next busy value so no valid beat leaks on the start cycle.
            rd_valid_q <= bus.RD_EN & ~busy_d;
        end
    end

    assign bus.DELAY_LINE_LOAD_0      = load_q;
    assign bus.DELAY_LINE_MOVE_0      = move_q;
    assign bus.DELAY_LINE_DIRECTION_0 = dir_q;
    assign bus.RX_BIT_SLIP_0          = slip_q;
    assign bus.RD_DATA                = rd_data_q;
    assign bus.RD_VALID               = rd_valid_q;
    assign bus.TRAIN_BUSY             = busy_q;
    assign bus.TRAIN_DONE             = done_q;
    assign bus.TRAIN_FAIL             = fail_q;
    assign bus.EYE_FIRST              = first_q;
    assign bus.EYE_LAST               = last_q;
    assign bus.CENTER_TAP             = center_q;

    a_pulse_onehot: assert property (@(posedge FAB_CLK) disable iff (ARST)
        $onehot0({load_q, move_q, slip_q}));

    a_no_valid_when_busy: assert property (@(posedge FAB_CLK) disable iff (ARST)
        rd_valid_q |-> !busy_q);

endmodule

// File: tb/tb_ddr4_dq_rx_train.sv
// Bench for ddr4_dq_rx_train: a delay-line/lane model answers LOAD/MOVE/SLIP pulses and a
// scoreboard holds the expected training and read-path results.
module tb_ddr4_dq_rx_train;

    localparam logic [3:0] Pattern = 4'b0101;
    localparam logic [3:0] BadWord = 4'b1010;

    typedef struct packed {
        logic [6:0]  first;
        logic [6:0]  last;
        logic [6:0]  center;
        logic        done;
        logic        fail;
        logic        busy;
        logic [15:0] slips;
        logic [15:0] loads;
        logic [15:0] inc;
        logic [15:0] dec;
        logic [7:0]  tap;
    } res_t;

    typedef struct packed {
        logic [3:0] data;
        logic       valid;
    } rd_t;

    logic clk  = 1'b0;
    logic arst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    res_t exp_q[$];
    rd_t  rd_q[$];

    // Lane model knobs
    int   eye_lo = 1000, eye_hi = -1, nar_lo = 1000, nar_hi = -1;
    int   slips_needed = 0, oor_tap = 1000, slip_base = 0;
    logic rd_force = 1'b0;
    logic [3:0] rd_word = 4'd0;
    logic lane_ok;

    // Monitor state
    int   model_tap = 0, n_load = 0, n_slip = 0, n_inc = 0, n_dec = 0, proto_err = 0;
    logic pend_slip = 1'b0;

    ddr4_dq_rx_train_if bus ();

    ddr4_dq_rx_train dut (
        .FAB_CLK (clk),
        .ARST    (arst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    always_comb begin
        lane_ok = 1'b0;
        if ((model_tap >= eye_lo && model_tap <= eye_hi) ||
            (model_tap >= nar_lo && model_tap <= nar_hi))
            lane_ok = ((n_slip - slip_base) >= slips_needed);
    end

    assign bus.RX_DATA_0 = rd_force ? rd_word : (lane_ok ? Pattern : BadWord);
    assign bus.DELAY_LINE_OUT_OF_RANGE_0 = (model_tap >= oor_tap);

    always @(negedge clk) begin
        proto_err <= proto_err
            + int'((int'(bus.DELAY_LINE_LOAD_0) + int'(bus.DELAY_LINE_MOVE_0)
                    + int'(bus.RX_BIT_SLIP_0)) > 1)
            + int'(pend_slip && (bus.DELAY_LINE_MOVE_0 || bus.RX_BIT_SLIP_0))
            + int'(bus.RD_VALID && bus.TRAIN_BUSY);
        if (bus.DELAY_LINE_LOAD_0) begin
            n_load    <= n_load + 1;
            model_tap <= 0;
        end else if (bus.DELAY_LINE_MOVE_0) begin
            if (bus.DELAY_LINE_DIRECTION_0) begin
                n_inc     <= n_inc + 1;
                model_tap <= model_tap + 1;
            end else begin
                n_dec     <= n_dec + 1;
                model_tap <= model_tap - 1;
            end
        end
        if (bus.RX_BIT_SLIP_0) n_slip <= n_slip + 1;
        pend_slip <= bus.DELAY_LINE_LOAD_0 ? 1'b0 : (bus.RX_BIT_SLIP_0 ? 1'b1 : pend_slip);
    end

    function automatic res_t make_exp(int first, int last, int center, bit done, bit fail,
                                      int slips, int loads, int inc, int dec, int tap);
        res_t r;
        r.first  = 7'(first);
        r.last   = 7'(last);
        r.center = 7'(center);
        r.done   = done;
        r.fail   = fail;
        r.busy   = 1'b0;
        r.slips  = 16'(slips);
        r.loads  = 16'(loads);
        r.inc    = 16'(inc);
        r.dec    = 16'(dec);
        r.tap    = 8'(tap);
        return r;
    endfunction

    // Starts a training run from a negedge, waits for BUSY to drop, scores against the queue.
    task automatic run_training(input string name, input int budget, input int restart_at);
        res_t got;
        res_t want;
        int   b_load, b_slip, b_inc, b_dec;
        bit   finished;
        b_load    = n_load;
        b_slip    = n_slip;
        b_inc     = n_inc;
        b_dec     = n_dec;
        slip_base = n_slip;
        bus.TRAIN_START = 1'b1;
        @(negedge clk);
        bus.TRAIN_START = 1'b0;
        tests++;
        if (bus.TRAIN_BUSY !== 1'b1) begin
            fails++;
            $display("FAIL %s busy_rise got %b want 1", name, bus.TRAIN_BUSY);
        end
        finished = 1'b0;
        for (int i = 0; i < budget; i++) begin
            bus.TRAIN_START = (i == restart_at);
            @(negedge clk);
            if (bus.TRAIN_BUSY === 1'b0) begin
                finished = 1'b1;
                break;
            end
        end
        bus.TRAIN_START = 1'b0;
        tests++;
        if (!finished) begin
            fails++;
            $display("FAIL %s timeout busy still %b after %0d cycles", name, bus.TRAIN_BUSY,
                     budget);
        end
        got.first  = bus.EYE_FIRST;
        got.last   = bus.EYE_LAST;
        got.center = bus.CENTER_TAP;
        got.done   = bus.TRAIN_DONE;
        got.fail   = bus.TRAIN_FAIL;
        got.busy   = bus.TRAIN_BUSY;
        got.slips  = 16'(n_slip - b_slip);
        got.loads  = 16'(n_load - b_load);
        got.inc    = 16'(n_inc - b_inc);
        got.dec    = 16'(n_dec - b_dec);
        got.tap    = 8'(model_tap);
        want = exp_q.pop_front();
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s result got %p want %p", name, got, want);
        end
        tests++;
        if (proto_err !== 0) begin
            fails++;
            $display("FAIL %s protocol_errors got %0d want 0", name, proto_err);
        end
    endtask

    task automatic test_reset();
        arst = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if ({bus.TRAIN_BUSY, bus.TRAIN_DONE, bus.TRAIN_FAIL, bus.EYE_FIRST, bus.EYE_LAST,
             bus.CENTER_TAP, bus.DELAY_LINE_LOAD_0, bus.DELAY_LINE_MOVE_0,
             bus.DELAY_LINE_DIRECTION_0, bus.RX_BIT_SLIP_0, bus.RD_DATA, bus.RD_VALID}
            !== 33'd0) begin
            fails++;
            $display("FAIL reset_outputs got busy=%b done=%b fail=%b first=%0d last=%0d want 0",
                     bus.TRAIN_BUSY, bus.TRAIN_DONE, bus.TRAIN_FAIL, bus.EYE_FIRST,
                     bus.EYE_LAST);
        end
        arst = 1'b0;
        repeat (20) @(negedge clk);
        tests++;
        if (n_load !== 0) begin
            fails++;
            $display("FAIL reset_no_load got %0d loads want 0", n_load);
        end
        tests++;
        if (bus.TRAIN_BUSY !== 1'b0 || bus.TRAIN_DONE !== 1'b0) begin
            fails++;
            $display("FAIL reset_idle got busy=%b done=%b want 0/0", bus.TRAIN_BUSY,
                     bus.TRAIN_DONE);
        end
    endtask

    task automatic test_basic_eye();
        eye_lo = 40; eye_hi = 59; slips_needed = 0;
        exp_q.push_back(make_exp(40, 59, 49, 1, 0, 0, 1, 60, 11, 49));
        run_training("basic_eye", 3000, 200);
    endtask

    task automatic test_slip();
        eye_lo = 10; eye_hi = 30; slips_needed = 2;
        exp_q.push_back(make_exp(10, 30, 20, 1, 0, 2, 3, 285, 11, 20));
        run_training("slip", 9000, -1);
    endtask

    task automatic test_fail();
        eye_lo = 10; eye_hi = 30; slips_needed = 1000;
        exp_q.push_back(make_exp(0, 0, 0, 0, 1, 4, 5, 635, 0, 127));
        run_training("no_eye_fail", 18000, -1);
    endtask

    task automatic test_narrow_wide();
        eye_lo = 70; eye_hi = 127; nar_lo = 5; nar_hi = 6; slips_needed = 0;
        exp_q.push_back(make_exp(70, 127, 98, 1, 0, 0, 1, 127, 29, 98));
        run_training("narrow_wide", 5000, -1);
        nar_lo = 1000; nar_hi = -1;
    endtask

    task automatic test_out_of_range();
        eye_lo = 60; eye_hi = 64; oor_tap = 64; slips_needed = 0;
        exp_q.push_back(make_exp(60, 64, 62, 1, 0, 0, 1, 64, 2, 62));
        run_training("out_of_range", 3000, -1);
        oor_tap = 1000;
    endtask

    task automatic test_arst_mid_sample();
        int b_load;
        eye_lo = 40; eye_hi = 59; slips_needed = 0;
        bus.TRAIN_START = 1'b1;
        @(negedge clk);
        bus.TRAIN_START = 1'b0;
        repeat (14) @(negedge clk);
        #2 arst = 1'b1;
        #1;
        tests++;
        if ({bus.TRAIN_BUSY, bus.TRAIN_DONE, bus.TRAIN_FAIL, bus.EYE_FIRST, bus.EYE_LAST,
             bus.CENTER_TAP, bus.DELAY_LINE_LOAD_0, bus.DELAY_LINE_MOVE_0,
             bus.RX_BIT_SLIP_0, bus.RD_VALID} !== 28'd0) begin
            fails++;
            $display("FAIL arst_mid_outputs got busy=%b load=%b move=%b want all 0",
                     bus.TRAIN_BUSY, bus.DELAY_LINE_LOAD_0, bus.DELAY_LINE_MOVE_0);
        end
        @(negedge clk);
        arst = 1'b0;
        b_load = n_load;
        repeat (40) @(negedge clk);
        tests++;
        if (n_load !== b_load || bus.TRAIN_BUSY !== 1'b0) begin
            fails++;
            $display("FAIL arst_no_relaunch got loads=%0d busy=%b want %0d/0", n_load,
                     bus.TRAIN_BUSY, b_load);
        end
        exp_q.push_back(make_exp(40, 59, 49, 1, 0, 0, 1, 60, 11, 49));
        run_training("retrain_after_arst", 3000, -1);
    endtask

    task automatic test_read_path();
        logic [3:0] words [4];
        logic       ens   [4];
        rd_t        want;
        words = '{4'hA, 4'h3, 4'hF, 4'h5};
        ens   = '{1'b1, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i <= 4; i++) begin
            if (rd_q.size() > 0) begin
                want = rd_q.pop_front();
                tests++;
                if ({bus.RD_DATA, bus.RD_VALID} !== want) begin
                    fails++;
                    $display("FAIL read_%0d got data=%h valid=%b want data=%h valid=%b", i - 1,
                             bus.RD_DATA, bus.RD_VALID, want.data, want.valid);
                end
            end
            if (i < 4) begin
                rd_force   = 1'b1;
                rd_word    = words[i];
                bus.RD_EN  = ens[i];
                rd_q.push_back('{data: words[i], valid: ens[i]});
            end
            @(negedge clk);
        end
        bus.RD_EN = 1'b0;
        rd_force  = 1'b0;
    endtask

    initial begin
        bus.TRAIN_START = 1'b0;
        bus.RD_EN       = 1'b0;
        test_reset();
        test_basic_eye();
        test_slip();
        test_fail();
        test_narrow_wide();
        test_out_of_range();
        test_arst_mid_sample();
        test_read_path();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
